// File: rtl/gen_pkg.sv
// Shared types and constants for the FIFO traffic generator.
package gen_pkg;

    // Run sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Fibonacci taps 8,6,5,4 expressed as a mask over q[7:0].
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam logic [7:0] SEED_DEF  = 8'hA5;
    localparam logic [7:0] DXOR_DEF  = 8'h3C;

    // Feedback bit: XOR of the tapped register bits.
    function automatic logic lfsr_fb(input logic [7:0] q);
        return ^(q & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR used to throttle pops while a run is active.
module lfsr8
    import gen_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       adv,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    // Load the seed on reset, shift in the feedback bit when advancing.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= seed;
        end else if (adv) begin
            q <= {q[6:0], lfsr_fb(q)};
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/fifo_traffic_gen.sv
// Transmit-side stimulus source: pushes a numbered, scrambled packet stream
// into one FIFO, flags one magic packet with start, and drains the FIFO with
// a pseudo-random pop pattern.
module fifo_traffic_gen
    import gen_pkg::*;
#(
    parameter int         WIDTH = 8,
    parameter int         CNTW  = 16,
    parameter logic [7:0] SEED  = SEED_DEF,
    parameter logic [7:0] DXOR  = DXOR_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             abort,
    input  logic [CNTW-1:0]  num_pkts,
    input  logic [CNTW-1:0]  magic_idx,
    input  logic [3:0]       burst_len,
    input  logic             full,
    input  logic             empty,
    output logic             push,
    output logic             pop,
    output logic             start,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] magic_data,
    output logic [CNTW-1:0]  sent_cnt,
    output logic [CNTW-1:0]  popped_cnt,
    output logic             done,
    output logic             magic_miss
);

    localparam logic [WIDTH-1:0] DXOR_W = WIDTH'(DXOR);

    state_t            state_r;
    state_t            state_nx_s;
    logic [CNTW-1:0]   num_r;
    logic [CNTW-1:0]   magic_idx_r;
    logic [3:0]        burst_cnt_r;
    logic              gap_r;
    logic              seen_r;
    logic [WIDTH-1:0]  data_r;
    logic [7:0]        lfsr_q_s;
    logic              lfsr_adv_s;
    logic              go_acc_s;
    logic              burst_hit_s;
    logic [CNTW-1:0]   sent_inc_s;

    assign lfsr_adv_s  = (state_r == RUN) || (state_r == DRAIN);
    assign go_acc_s    = (state_r == IDLE) && go && !abort;
    assign burst_hit_s = (burst_len != 4'd0) && ((burst_cnt_r + 4'd1) == burst_len);
    assign sent_inc_s  = sent_cnt + CNTW'(1);

    // Push is held off (never dropped) while full; abort kills it immediately.
    assign push  = !abort && (state_r == RUN) && !full && (sent_cnt < num_r) && !gap_r;
    assign start = push && (sent_cnt == magic_idx_r);
    assign pop   = !abort && !empty &&
                   ((state_r == DRAIN) || ((state_r == RUN) && lfsr_q_s[0]));
    assign data_out = data_r;
    assign done     = (state_r == DONE);

    lfsr8 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .adv  (lfsr_adv_s),
        .seed (SEED),
        .q    (lfsr_q_s)
    );

    // Next-state logic; abort returns to IDLE from any state.
    always_comb begin
        state_nx_s = state_r;
        if (abort) begin
            state_nx_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (go) begin
                        state_nx_s = (num_pkts != '0) ? RUN : DRAIN;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end
                RUN: begin
                    if (sent_cnt == num_r) begin
                        state_nx_s = DRAIN;
                    end else begin
                        state_nx_s = RUN;
                    end
                end
                DRAIN: begin
                    if (empty && !pop) begin
                        state_nx_s = DONE;
                    end else begin
                        state_nx_s = DRAIN;
                    end
                end
                DONE:    state_nx_s = IDLE;
                default: state_nx_s = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Run parameters, counters, burst gap tracking and magic capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            num_r       <= '0;
            magic_idx_r <= '0;
            sent_cnt    <= '0;
            popped_cnt  <= '0;
            magic_miss  <= 1'b0;
            magic_data  <= '0;
            seen_r      <= 1'b0;
            data_r      <= '0;
            burst_cnt_r <= 4'd0;
            gap_r       <= 1'b0;
        end else if (go_acc_s) begin
            num_r       <= num_pkts;
            magic_idx_r <= magic_idx;
            sent_cnt    <= '0;
            popped_cnt  <= '0;
            magic_miss  <= 1'b0;
            magic_data  <= '0;
            seen_r      <= 1'b0;
            data_r      <= DXOR_W;
            burst_cnt_r <= 4'd0;
            gap_r       <= 1'b0;
        end else begin
            if (push) begin
                sent_cnt    <= sent_inc_s;
                data_r      <= sent_inc_s[WIDTH-1:0] ^ DXOR_W;
                burst_cnt_r <= burst_hit_s ? 4'd0 : (burst_cnt_r + 4'd1);
            end
            if (pop) begin
                popped_cnt <= popped_cnt + CNTW'(1);
            end
            if (start) begin
                seen_r     <= 1'b1;
                magic_data <= data_r;
            end
            if ((state_r == DRAIN) && (state_nx_s == DONE) && !seen_r) begin
                magic_miss <= 1'b1;
            end
            // One idle cycle follows each completed burst.
            gap_r <= push && burst_hit_s;
        end
    end

endmodule

// File: tb/tb_fifo_traffic_gen.sv
// Randomized self-checking bench for fifo_traffic_gen with a behavioural
// reference model and a queue standing in for the FIFO under test.
module tb_fifo_traffic_gen;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst, go, abort, full, empty;
    logic [15:0] num_pkts, magic_idx;
    logic [3:0]  burst_len;
    logic        push, pop, start, done, magic_miss;
    logic [7:0]  data_out, magic_data;
    logic [15:0] sent_cnt, popped_cnt;

    always #5 clk = ~clk;

    fifo_traffic_gen #(.WIDTH(8), .CNTW(16), .SEED(8'hA5), .DXOR(8'h3C)) dut (
        .clk(clk), .rst(rst), .go(go), .abort(abort),
        .num_pkts(num_pkts), .magic_idx(magic_idx), .burst_len(burst_len),
        .full(full), .empty(empty),
        .push(push), .pop(pop), .start(start),
        .data_out(data_out), .magic_data(magic_data),
        .sent_cnt(sent_cnt), .popped_cnt(popped_cnt),
        .done(done), .magic_miss(magic_miss)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: phase 0 idle, 1 sending, 2 draining, 3 finished.
    int         m_phase = 0;
    int         m_num = 0, m_magic = 0, m_sent = 0, m_popped = 0;
    bit         m_miss = 0, m_seen = 0, m_gap = 0, m_started = 0;
    logic [7:0] m_mdata = 8'h00;
    logic [7:0] m_lfsr = 8'hA5;
    bit         e_push = 0, e_pop = 0, e_start = 0;
    bit         force_full = 0;
    logic [7:0] fifo_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_data();
        return m_started ? (8'(m_sent) ^ 8'h3C) : 8'h00;
    endfunction

    // Advance the model across one clock edge.
    function automatic void model_update();
        int  old_sent;
        bit  next_gap;
        if (e_pop)  void'(fifo_q.pop_front());
        if (e_push) fifo_q.push_back(m_data());
        if (!rst) begin
            m_phase = 0; m_num = 0; m_magic = 0; m_sent = 0; m_popped = 0;
            m_miss = 0; m_seen = 0; m_gap = 0; m_started = 0;
            m_mdata = 8'h00; m_lfsr = 8'hA5;
            return;
        end
        if (m_phase == 1 || m_phase == 2)
            m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
        next_gap = e_push && (burst_len != 4'd0) && (((m_sent + 1) % int'(burst_len)) == 0);
        old_sent = m_sent;
        if (e_start) begin m_seen = 1; m_mdata = m_data(); end
        if (e_push) m_sent++;
        if (e_pop)  m_popped++;
        m_gap = next_gap;
        if (abort) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: if (go) begin
                    m_num = int'(num_pkts); m_magic = int'(magic_idx);
                    m_sent = 0; m_popped = 0; m_miss = 0; m_seen = 0;
                    m_mdata = 8'h00; m_started = 1; m_gap = 0;
                    m_phase = (num_pkts != 16'd0) ? 1 : 2;
                end
                1: if (old_sent == m_num) m_phase = 2;
                2: if (empty) begin m_phase = 3; if (!m_seen) m_miss = 1; end
                default: m_phase = 0;
            endcase
        end
    endfunction

    // One cycle: drive FIFO flags, compare at negedge, update model at posedge.
    task automatic step();
        full  = force_full || (fifo_q.size() >= DEPTH);
        empty = (fifo_q.size() == 0);
        @(negedge clk);
        e_push  = (m_phase == 1) && !abort && !full && (m_sent < m_num) && !m_gap;
        e_start = e_push && (m_sent == m_magic);
        e_pop   = !empty && !abort && ((m_phase == 2) || (m_phase == 1 && m_lfsr[0]));
        check_eq("push", push, e_push);
        check_eq("pop", pop, e_pop);
        check_eq("start", start, e_start);
        check_eq("data_out", data_out, m_data());
        check_eq("magic_data", magic_data, m_mdata);
        check_eq("sent_cnt", sent_cnt, 16'(m_sent));
        check_eq("popped_cnt", popped_cnt, 16'(m_popped));
        check_eq("done", done, m_phase == 3);
        check_eq("magic_miss", magic_miss, m_miss);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_run(input int num, input int magic, input int blen, input int full_pct,
                          input int full_at, input int full_len, input int abort_at, input int rst_at);
        int cyc  = 0;
        bit left = 0;
        num_pkts  = 16'(num);
        magic_idx = 16'(magic);
        burst_len = 4'(blen);
        go = 1'b1;
        while (cyc < 400) begin
            abort = (cyc == abort_at);
            rst   = !(cyc == rst_at);
            force_full = (cyc >= full_at && cyc < full_at + full_len) ||
                         (int'($urandom_range(99)) < full_pct);
            step();
            go = 1'b0;
            cyc++;
            if (m_phase != 0) left = 1;
            if (left && m_phase == 0) break;
        end
        check_eq("run_end_idle", 32'(m_phase), 32'd0);
        abort = 1'b0;
        rst = 1'b1;
        force_full = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b0; go = 1'b0; abort = 1'b0; full = 1'b0; empty = 1'b1;
        num_pkts = 16'd0; magic_idx = 16'd0; burst_len = 4'd0;
        @(posedge clk);
        model_update();
        #1;
        step();
        step();
        rst = 1'b1;
        step();

        // Basic stream: data 3C..3F, magic at index 2.
        do_run(4, 2, 0, 0, -1, 0, -1, -1);
        check_eq("t1_magic_data", magic_data, 8'h3E);
        check_eq("t1_sent", sent_cnt, 16'd4);
        check_eq("t1_popped", popped_cnt, 16'd4);
        check_eq("t1_no_miss", magic_miss, 1'b0);

        // Bursts of two with one idle cycle between.
        do_run(6, 0, 2, 0, -1, 0, -1, -1);
        check_eq("t2_sent", sent_cnt, 16'd6);
        check_eq("t2_popped", popped_cnt, 16'd6);

        // Full held five cycles mid-run.
        do_run(7, 5, 0, 0, 3, 5, -1, -1);
        check_eq("t3_sent", sent_cnt, 16'd7);

        // Magic index out of range.
        do_run(4, 9, 0, 0, -1, 0, -1, -1);
        check_eq("t4_miss", magic_miss, 1'b1);

        // Abort after three pushes, then a fresh run.
        do_run(8, 6, 0, 0, -1, 0, 4, -1);
        check_eq("t5_sent_held", sent_cnt, 16'd3);
        do_run(3, 1, 0, 0, -1, 0, -1, -1);
        check_eq("t5_new_sent", sent_cnt, 16'd3);
        check_eq("t5_miss_clear", magic_miss, 1'b0);

        // Reset while draining, then an empty run.
        do_run(8, 1, 0, 0, -1, 0, -1, 10);
        check_eq("t6_rst_sent", sent_cnt, 16'd0);
        do_run(0, 0, 0, 0, -1, 0, -1, -1);

        // Random runs.
        for (int r = 0; r < 14; r++) begin
            int n, mg, bl, fp, ab;
            n  = int'($urandom_range(12));
            mg = int'($urandom_range(14));
            bl = int'($urandom_range(4));
            fp = int'($urandom_range(40));
            ab = ($urandom_range(99) < 20) ? int'($urandom_range(1, 10)) : -1;
            do_run(n, mg, bl, fp, -1, 0, ab, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
